// File: rtl/pipe_trace_buf.sv
// Pipeline trace capture: circular buffer of {stamp, pc, stage_ins}, HALT-triggered freeze, oldest-first readout.
// Latency: writes take effect at the sampling edge; a pop shows rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; the core is never stalled, and the oldest entry is overwritten when the buffer is full.
//
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   en, pc          sample qualifier and fetch PC of the current cycle
//   stage_ins       per-stage instruction words, stage 0 = ID in the low word, last stage = WB
//   rearm           pulse: empty the buffer and return to capture
//   rd_en           pop request, honoured only once capture is done and entries remain
//   rd_data         popped entry {stamp, pc, stage_ins}, valid when rd_valid is high
//   count           entries held
//   done, triggered capture status decoded from the state register
module pipe_trace_buf #(
   parameter int unsigned NUM_STAGE = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned POST_TRIG = 4,
   parameter logic [5:0]  HALT_OP   = 6'h3f
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [31:0]                   pc,
   input  logic [32*NUM_STAGE-1:0]       stage_ins,
   input  logic                          rearm,
   input  logic                          rd_en,
   output logic [32*(NUM_STAGE+2)-1:0]   rd_data,
   output logic                          rd_valid,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          done,
   output logic                          triggered
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = 32 * (NUM_STAGE + 2);
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_ARM,
      ST_POST,
      ST_DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [31:0]       stamp;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     post_cnt;
   logic [EW-1:0]     mem [DEPTH];
   logic              trig;
   logic              wr_go;
   logic              pop_go;
   logic              full;

   // Only the opcode field of the last-stage word is inspected.
   assign trig = (stage_ins[32*NUM_STAGE-1 -: 6] == HALT_OP);
   assign full = (count == CNT_FULL);

   assign done      = (state == ST_DONE);
   assign triggered = (state != ST_ARM);

   // Next-state and datapath strobes. rearm dominates every other request.
   always_comb begin
      state_nxt = state;
      wr_go     = 1'b0;
      pop_go    = 1'b0;
      if (rearm) begin
         state_nxt = ST_ARM;
      end else begin
         case (state)
            ST_ARM: begin
               wr_go = en;
               if (en && trig) begin
                  state_nxt = (POST_TRIG == 0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               wr_go = en;
               if (en && (post_cnt == AW'(1))) begin
                  state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               pop_go = rd_en && (count != '0);
            end
            default: begin
               state_nxt = ST_ARM;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_ARM;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stamp    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         post_cnt <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         // Timestamp runs on every clock, independent of capture state.
         stamp <= stamp + 32'd1;
         if (rearm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= pop_go;
            if (wr_go) begin
               wr_ptr <= wr_ptr + AW'(1);
               // A full buffer drops its oldest entry to make room.
               if (full) begin
                  rd_ptr <= rd_ptr + AW'(1);
               end else begin
                  count <= count + (AW + 1)'(1);
               end
               if (state == ST_ARM) begin
                  if (trig) begin
                     post_cnt <= AW'(POST_TRIG);
                  end
               end else begin
                  post_cnt <= post_cnt - AW'(1);
               end
            end
            if (pop_go) begin
               rd_data <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + AW'(1);
               count   <= count - (AW + 1)'(1);
            end
         end
      end
   end

   // Storage is not reset; entries are only ever read after being written.
   always_ff @(posedge clk) begin
      if (rst && wr_go) begin
         mem[wr_ptr] <= {stamp, pc, stage_ins};
      end
   end

endmodule

// File: tb/tb_pipe_trace_buf.sv
module tb_pipe_trace_buf;

   localparam int MDEPTH = 16;
   localparam int MPOST  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [31:0]   pc;
   logic [127:0]  stage_ins;
   logic          rearm;
   logic          rd_en;
   logic [191:0]  rd_data;
   logic          rd_valid;
   logic [4:0]    count;
   logic          done;
   logic          triggered;

   // Second instance: POST_TRIG=0, small buffer, own control inputs.
   logic          en1;
   logic          rearm1;
   logic          rd_en1;
   logic [191:0]  rd_data1;
   logic          rd_valid1;
   logic [2:0]    count1;
   logic          done1;
   logic          triggered1;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of entries, capture phase as plain integers.
   logic [191:0]  mq[$];
   int            m_phase;      // 0 capturing, 1 post-trigger, 2 frozen
   int            m_left;
   logic [31:0]   m_stamp;
   logic [191:0]  m_rd_data;
   bit            m_rd_valid;

   pipe_trace_buf #(.NUM_STAGE(4), .DEPTH(MDEPTH), .POST_TRIG(MPOST), .HALT_OP(6'h3f)) u_dut (
      .clk(clk), .rst(rst), .en(en), .pc(pc), .stage_ins(stage_ins), .rearm(rearm),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
      .done(done), .triggered(triggered));

   pipe_trace_buf #(.NUM_STAGE(4), .DEPTH(4), .POST_TRIG(0), .HALT_OP(6'h3f)) u_dut0 (
      .clk(clk), .rst(rst), .en(en1), .pc(pc), .stage_ins(stage_ins), .rearm(rearm1),
      .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1),
      .done(done1), .triggered(triggered1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] ins_word(input bit halt);
      logic [127:0] w;
      w = {$urandom, $urandom, $urandom, $urandom};
      if (halt) w[127:96] = 32'hFFFF_FFFF;
      else if (w[127:122] == 6'h3f) w[127:122] = 6'h00;
      return w;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_phase    = 0;
      m_left     = 0;
      m_stamp    = 32'd0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
   endtask

   task automatic model_step(input bit e, input logic [31:0] p, input logic [127:0] s,
                             input bit ra, input bit re);
      logic [191:0] dummy;
      if (ra) begin
         mq.delete();
         m_phase    = 0;
         m_left     = 0;
         m_rd_valid = 1'b0;
      end else begin
         m_rd_valid = 1'b0;
         if (m_phase == 2) begin
            if (re && mq.size() > 0) begin
               m_rd_data  = mq.pop_front();
               m_rd_valid = 1'b1;
            end
         end else if (e) begin
            mq.push_back({m_stamp, p, s});
            if (mq.size() > MDEPTH) dummy = mq.pop_front();
            if (m_phase == 0) begin
               if (s[127:122] == 6'h3f) begin
                  m_left  = MPOST;
                  m_phase = (MPOST == 0) ? 2 : 1;
               end
            end else begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
         end
      end
      m_stamp = m_stamp + 32'd1;
   endtask

   task automatic check_main();
      chk("count", 192'(count), 192'(mq.size()));
      chk("done", 192'(done), 192'(m_phase == 2));
      chk("triggered", 192'(triggered), 192'(m_phase != 0));
      chk("rd_valid", 192'(rd_valid), 192'(m_rd_valid));
      chk("rd_data", rd_data, m_rd_data);
   endtask

   task automatic step(input bit e, input logic [31:0] p, input logic [127:0] s,
                       input bit ra, input bit re);
      en = e; pc = p; stage_ins = s; rearm = ra; rd_en = re;
      model_step(e, p, s, ra, re);
      @(posedge clk);
      #1;
      check_main();
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; rearm = 1'b0; rd_en = 1'b0;
      en1 = 1'b0; rearm1 = 1'b0; rd_en1 = 1'b0;
      pc = '0; stage_ins = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_main();
      rst = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && mq.size() > 0; i++) step(0, 32'd0, '0, 0, 1);
   endtask

   initial begin
      logic [31:0] first_stamp;
      int n;

      // Reset, then one idle cycle so the release edge consumes stamp 0.
      do_reset();
      chk("rst_done1", 192'(done1), 192'(0));
      step(0, 32'd0, '0, 0, 0);

      // Five plain captures, then trigger to freeze and inspect the oldest entry.
      for (int k = 0; k < 5; k++) step(1, 32'(4 * k), ins_word(0), 0, 0);
      chk("t1_count", 192'(count), 192'(5));
      chk("t1_done", 192'(done), 192'(0));
      chk("t1_trig", 192'(triggered), 192'(0));
      step(1, 32'h14, ins_word(1), 0, 0);
      for (int k = 0; k < 4; k++) step(1, 32'(32'h18 + 4 * k), ins_word(0), 0, 0);
      chk("t1_frozen", 192'(done), 192'(1));
      step(0, 32'd0, '0, 0, 1);
      first_stamp = rd_data[191:160];
      chk("t1_first_stamp", 192'(first_stamp), 192'(1));
      chk("t1_first_pc", 192'(rd_data[159:128]), 192'(0));
      drain();

      // 30 captures, HALT on cycle 20: freeze after cycle 24, buffer holds cycles 9..24.
      step(0, 32'd0, '0, 1, 0);
      for (int k = 1; k <= 30; k++) begin
         step(1, 32'(k), ins_word(k == 20), 0, 0);
         if (k == 23) chk("t2_not_done_yet", 192'(done), 192'(0));
         if (k == 24) chk("t2_done", 192'(done), 192'(1));
      end
      chk("t2_count", 192'(count), 192'(16));
      for (int i = 0; i < 16; i++) begin
         step(0, 32'd0, '0, 0, 1);
         chk("t2_pop_pc", 192'(rd_data[159:128]), 192'(9 + i));
         step(0, 32'd0, '0, 0, 0);
      end
      // Popping an empty frozen buffer does nothing.
      for (int i = 0; i < 3; i++) begin
         step(0, 32'd0, '0, 0, 1);
         chk("t6_valid", 192'(rd_valid), 192'(0));
         chk("t6_count", 192'(count), 192'(0));
         chk("t6_done", 192'(done), 192'(1));
      end

      // en toggling during post-trigger; an extra HALT there is ignored.
      step(0, 32'd0, '0, 1, 0);
      for (int k = 0; k < 3; k++) step(1, $urandom, ins_word(0), 0, 0);
      step(1, $urandom, ins_word(1), 0, 0);
      n = 0;
      while (!done && n < 40) begin
         step(n[0] == 1'b0, $urandom, ins_word(n == 2), 0, 0);
         n++;
      end
      chk("t3_done", 192'(done), 192'(1));
      chk("t3_count", 192'(count), 192'(8));
      drain();

      // rearm wins over a simultaneous HALT; a later HALT triggers.
      step(1, 32'h40, ins_word(1), 1, 0);
      chk("t4_trig", 192'(triggered), 192'(0));
      chk("t4_count", 192'(count), 192'(0));
      step(1, 32'h44, ins_word(0), 0, 0);
      step(1, 32'h48, ins_word(1), 0, 0);
      chk("t4_retrig", 192'(triggered), 192'(1));

      // Randomised traffic, including buffer wrap, rearms and pops.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 3) != 0, $urandom, ins_word($urandom_range(0, 19) == 0),
              $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);
      end

      // Reset mid post-trigger discards everything.
      step(0, 32'd0, '0, 1, 0);
      step(1, 32'h80, ins_word(1), 0, 0);
      step(1, 32'h84, ins_word(0), 0, 0);
      do_reset();
      chk("t7_count", 192'(count), 192'(0));
      chk("t7_trig", 192'(triggered), 192'(0));

      // POST_TRIG=0 instance: HALT on the first capture freezes immediately.
      en1 = 1'b1;
      step(0, 32'h100, ins_word(1), 0, 0);
      en1 = 1'b0;
      chk("p0_done", 192'(done1), 192'(1));
      chk("p0_count", 192'(count1), 192'(1));
      rd_en1 = 1'b1;
      step(0, 32'd0, '0, 0, 0);
      rd_en1 = 1'b0;
      chk("p0_valid", 192'(rd_valid1), 192'(1));
      chk("p0_top_word", 192'(rd_data1[127:96]), 192'(32'hFFFF_FFFF));
      chk("p0_pc", 192'(rd_data1[159:128]), 192'(32'h100));
      chk("p0_empty", 192'(count1), 192'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_trace_buf.md
# pipe_trace_buf

Hardware trace capture for the five-stage MIPS pipeline. Each enabled cycle it records a timestamp, the fetch PC and the instruction word held by every pipeline stage into a circular buffer. A HALT reaching the last stage triggers a parametrised number of post-trigger samples, after which the buffer freezes. The stored history is then read out oldest-first. The block sits beside `pipeline` on the same clock and snoops the per-stage instruction buses (ID/EX/DM/WB) and the PC; it never drives the core.

## Interface
Parameters:
- NUM_STAGE, 4, number of snooped stage instruction words; stage NUM_STAGE-1 is the last (WB) stage.
- DEPTH, 16, buffer entries; power of two, minimum 2.
- POST_TRIG, 4, samples recorded after the trigger sample; range 0..DEPTH-1.
- HALT_OP, 6'h3f, opcode that constitutes the trigger.

Derived: AW = log2(DEPTH); EW = 32*(NUM_STAGE+2), the entry width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  sample-enable qualifier for the current cycle.
- pc  in  32  fetch PC of the current cycle.
- stage_ins  in  32*NUM_STAGE  stage instruction words; stage k occupies bits [32k+31:32k]; k=0 is ID.
- rearm  in  1  single-cycle pulse that clears the buffer and re-arms capture.
- rd_en  in  1  pop request; honoured only in DONE with count>0.
- rd_data  out  EW  popped entry, laid out as {stamp[31:0], pc[31:0], stage_ins}.
- rd_valid  out  1  rd_data is valid this cycle.
- count  out  AW+1  number of entries held.
- done  out  1  high while in DONE.
- triggered  out  1  high in POST and DONE.

## Operation
- Free-running 32-bit stamp counter: 0 on reset; +1 every clock regardless of state or en; wraps 0xFFFFFFFF→0.
- Entry write: {stamp, pc, stage_ins} goes to mem[wr_ptr]; then wr_ptr+1 mod DEPTH.
  - If count==DEPTH before the write, rd_ptr also advances, overwriting the oldest entry.
  - Otherwise count+1.
- Trigger condition: stage_ins[32*NUM_STAGE-1 -: 6]==HALT_OP. Only the opcode is compared; there is no NOP/operand qualification.
- States:
  - ARM: every en cycle writes an entry. On an en cycle with the trigger condition true:
    - the entry is written;
    - post_cnt loads POST_TRIG;
    - next state is POST, or DONE if POST_TRIG==0.
  - POST: every en cycle writes an entry and decrements post_cnt. The en cycle on which post_cnt goes 1→0 writes its entry and moves to DONE. Further HALTs in this state are ignored.
  - DONE: no writes. Each rd_en with count>0:
    - rd_data←mem[rd_ptr];
    - rd_ptr+1 mod DEPTH;
    - count−1;
    - rd_valid=1 on the following cycle.
    - rd_en with count==0 is ignored (rd_valid stays 0).
    - The block remains in DONE after the buffer empties.
- en low: no write and no post_cnt change in any state.
- rearm (any state): next cycle state=ARM, wr_ptr=rd_ptr=0, count=0, post_cnt=0, rd_valid=0.
  - rearm beats a simultaneous trigger or rd_en. The sample on a rearm cycle is not written.
  - rd_data holds its value.
- Reset values: state=ARM, stamp=0, wr_ptr=rd_ptr=0, count=0, post_cnt=0, rd_data=0, rd_valid=0, done=0, triggered=0. Memory contents are not reset.
- Reset asserted mid-POST or mid-readout: all of the above apply on the next edge and the captured data is lost.

## Timing
- Write: inputs sampled at edge N; count/pointers update at N.
- Pop: rd_en sampled at edge N; rd_data and rd_valid registered at N, so both are visible in cycle N+1. Back-to-back pops give one entry per cycle.
- Trigger at edge N, POST_TRIG=P, en continuously high: done=1 after edge N+P.
- done and triggered are decoded directly from the state register, with no extra latency.

## Test plan
- Reset then 5 en cycles with no HALT, pc=0x0,0x4,…,0x10 → count=5, done=0, triggered=0, stamp of the first entry=1 (reset release at stamp 0).
- DEPTH=16, POST_TRIG=4: 30 en cycles, HALT (0xFFFFFFFF) in the WB slot on cycle 20 → done after cycle 24; count=16; pops return pc of cycles 9..24 in order, each with rd_valid exactly 1 cycle after rd_en.
- POST_TRIG=0: HALT on the first en cycle → done on the next cycle, count=1, popped stage_ins top word=0xFFFFFFFF.
- en toggling 1/0 during POST → only en cycles are counted; exactly POST_TRIG entries follow the trigger entry; stamps show the gaps.
- rearm asserted in the same cycle as a HALT → state ARM, count=0, no trigger; next HALT triggers normally.
- In DONE, pop until count=0, then 3 more rd_en → rd_valid stays 0, count stays 0, done stays 1.
